// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: segment type, blank pattern and hex-to-segment table shared by the scanner.
package sevenseg_pkg;
  typedef logic [6:0] seg_t;
  localparam seg_t SEG_OFF = 7'h00;
  localparam seg_t SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: combinational nibble to {g..a} active-high segment pattern; ports nib (in 4), seg (out seg_t).
module hex_to_seg
  import sevenseg_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);
  assign seg = SEG_HEX[nib];
endmodule

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: time-multiplexed seven-segment driver; clk, reset (sync, high), load/value/dp_in/blank_in in, an_out/seg_out/dp_out/frame_tick out; SEVENSEG_DIM_EN adds brightness.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int N_DIGITS    = 8,
  parameter int SCAN_LOG    = 16,
  parameter int DEAD_CYCLES = 64,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
`ifdef SEVENSEG_DIM_EN
  input  logic [3:0]            brightness,
`endif
  output logic [N_DIGITS-1:0]   an_out,
  output seg_t                  seg_out,
  output logic                  dp_out,
  output logic                  frame_tick
);
  localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_DIGITS - 1);
  localparam logic [SCAN_LOG-1:0] DEAD = SCAN_LOG'(DEAD_CYCLES);
  localparam logic POL = 1'(ACTIVE_LOW);
  logic [SCAN_LOG-1:0]   cnt;
  logic [IW-1:0]         idx;
  logic [4*N_DIGITS-1:0] val_q;
  logic [N_DIGITS-1:0]   dp_q, blank_q;
  logic                  on;
  seg_t                  seg;
  hex_to_seg u_dec (.nib(val_q[{idx, 2'b00} +: 4]), .seg(seg));
`ifdef SEVENSEG_DIM_EN
  assign on = cnt >= DEAD && !blank_q[idx] && cnt[SCAN_LOG-1 -: 4] <= brightness;
`else
  assign on = cnt >= DEAD && !blank_q[idx];
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      val_q      <= '0;
      dp_q       <= '0;
      blank_q    <= '1;
      an_out     <= {N_DIGITS{POL}};
      seg_out    <= {7{POL}};
      dp_out     <= POL;
      frame_tick <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      if (&cnt) idx <= idx == LAST ? '0 : idx + 1'b1;
      if (load) begin
        val_q   <= value;
        dp_q    <= dp_in;
        blank_q <= blank_in;
      end
      an_out     <= (on ? N_DIGITS'(1) << idx : '0) ^ {N_DIGITS{POL}};
      seg_out    <= (on ? seg : SEG_OFF) ^ {7{POL}};
      dp_out     <= (on & dp_q[idx]) ^ POL;
      frame_tick <= &cnt && idx == LAST;
    end
  end
endmodule

// File: doc/sevenseg_scan.md
# sevenseg_scan

Time-multiplexed driver for a bank of common-anode/cathode seven-segment digits. Latches a hex value, decimal points and a per-digit blank mask on a load strobe. Scans one digit at a time with a configurable slot length and anti-ghosting dead time. Sits at the board output pins, opposite the input debouncer, between game/debug logic and the display.

## Interface
- `N_DIGITS`, 8: number of digits, 1..16; need not be a power of two.
- `SCAN_LOG`, 16: slot length is 2^SCAN_LOG clk cycles per digit; must be ≥5.
- `DEAD_CYCLES`, 64: cycles at the start of each slot with all anodes off; must be < 2^SCAN_LOG.
- `ACTIVE_LOW`, 1: 1 inverts all anode, segment and dp outputs; 0 is active-high.
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high.
- `load`  in  1: one-cycle strobe; captures `value`, `dp_in`, `blank_in`.
- `value`  in  4*N_DIGITS: nibble i is the hex digit for digit i.
- `dp_in`  in  N_DIGITS: decimal point per digit.
- `blank_in`  in  N_DIGITS: 1 means the digit is dark.
- `brightness`  in  4: dimming level; present only with the macro.
- `an_out`  out  N_DIGITS: digit enables.
- `seg_out`  out  7: {g,f,e,d,c,b,a}; bit 0 is segment a.
- `dp_out`  out  1: decimal point.
- `frame_tick`  out  1: one-cycle pulse when the digit index wraps to 0.

## Operation
- Shadow registers: `val_q`, `dp_q`, `blank_q`.
  - Updated on any cycle with `load`=1.
  - Hold otherwise.
- Slot counter `cnt` (SCAN_LOG bits): free-running and wraps.
  - When `cnt`=all-ones, digit index `idx` advances: `idx` = N_DIGITS-1 goes to 0, otherwise `idx`+1.
- Digit enable: `on` = (`cnt` ≥ DEAD_CYCLES) & ~`blank_q[idx]`.
  - Only `an_out[idx]` may be active.
  - All other anodes are always inactive.
- Segment pattern: hex decode of `val_q[idx]`, active-high before polarity.
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- `dp_out` = `dp_q[idx]`.
- When `on`=0, segments and dp are also driven off.
- Polarity: every output bit is XORed with ACTIVE_LOW, except `frame_tick`, which is always active-high.
- `frame_tick` = 1 in the cycle after `idx` becomes 0.
- Reset values:
  - `cnt`=0, `idx`=0, `val_q`=0, `dp_q`=0, `blank_q`=all ones.
  - `an_out`, `seg_out`, `dp_out` at their inactive level.
  - `frame_tick`=0.
- Reset mid-scan: the next cycle restarts at digit 0, `cnt`=0, with everything dark until the next `load`.
- `load` during the active part of a slot: the new pattern is shown immediately, with no wait for the slot boundary.

## Timing
- All outputs registered; one cycle from internal state to pins.
- `load` sampled at edge k → `seg_out`/`an_out` reflect the new data after edge k+1.
- Digit 0 anode first goes active after edge DEAD_CYCLES+1 following reset release, provided a `load` occurred earlier.
- Slot boundary: `an_out` goes inactive for exactly DEAD_CYCLES cycles between consecutive digits.
- Full frame: N_DIGITS·2^SCAN_LOG cycles; `frame_tick` period equals this.
- `load` and a slot wrap in the same cycle: both take effect, and the new digit shows the newly loaded data.

## Configuration
- `SEVENSEG_DIM_EN` defined:
  - Adds the `brightness` port.
  - `on` additionally requires `cnt[SCAN_LOG-1 -: 4]` ≤ `brightness`.
  - 15 = full slot; 0 = first 1/16 of the slot (minus dead time).
  - `brightness` is sampled combinationally each cycle; no latching.
- Not defined: no port; full duty except dead time.

## Structure
- Package `sevenseg_pkg`:
  - `SEG_HEX` constant array[16] of 7-bit patterns.
  - `seg_t` typedef (logic [6:0]).
  - `SEG_OFF` constant.
- Sub-module `hex_to_seg`: combinational nibble → `seg_t` lookup from `SEG_HEX`, instantiated once on the selected nibble.
- Top holds the shadow registers, counters, enable logic and output registers.

## Test plan
- Reset:
  - Stimulus: ACTIVE_LOW=1, assert reset 3 cycles.
  - Required: `an_out`=all ones, `seg_out`=7F, `dp_out`=1, `frame_tick`=0 the cycle after; outputs stay dark with no `load`.
- Scan sequence:
  - Stimulus: N_DIGITS=8, SCAN_LOG=5, DEAD_CYCLES=4, ACTIVE_LOW=0; load `value`=32'h0123ABCD, `blank_in`=0.
  - Required: digit i sees `seg_out`=SEG_HEX[nibble i] (digit 0 → 5E).
  - Required: `an_out` one-hot, active 28 of 32 cycles per slot, 4 dark cycles between slots.
  - Required: `frame_tick` every 256 cycles.
- Blank and dp:
  - Stimulus: `blank_in`=8'h02, `dp_in`=8'h04.
  - Required: digit 1 slot has `an_out`=0 and `seg_out`=00; `dp_out`=1 only during digit 2's active window.
- Non-power-of-two wrap:
  - Stimulus: N_DIGITS=6.
  - Required: `idx` goes 5→0; `an_out[5]` is followed by `an_out[0]` after the dead time; frame = 192 cycles.
- Mid-slot load and simultaneity:
  - Stimulus: load during the active part of digit 3; separately, load coincident with `cnt` wrap.
  - Required: the new pattern appears at k+1 in both cases; the next digit shows the new data.
- `SEVENSEG_DIM_EN`:
  - Stimulus: `brightness`=3, SCAN_LOG=5.
  - Required: anode active for `cnt` 4..7 only (4 cycles per slot).
  - Required: `brightness`=15 gives the same result as the macro undefined.
